mf_window_sequencer: RTL

//  Streams raster pixels into two line buffers and sequences 3x3 windows (P1..P9) for
//  the noisy-pixel counter / control-signal generator and mean-filter datapath.

---
 rtl/mf_pkg.sv | 28 ++
 rtl/mf_line_buffer.sv | 26 ++
 rtl/mf_window_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mf_pkg.sv
// Shared types and constants for the mean-filter window sequencer.
// Tap indices are row-major, P5 is the window centre.
package mf_pkg;

    localparam int unsigned PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StEol,
        StFlush
    } state_e;

    localparam int unsigned TAP_P1 = 0;
    localparam int unsigned TAP_P2 = 1;
    localparam int unsigned TAP_P3 = 2;
    localparam int unsigned TAP_P4 = 3;
    localparam int unsigned TAP_P5 = 4;
    localparam int unsigned TAP_P6 = 5;
    localparam int unsigned TAP_P7 = 6;
    localparam int unsigned TAP_P8 = 7;
    localparam int unsigned TAP_P9 = 8;
    localparam int unsigned TAP_N  = 9;

endpackage

// File: rtl/mf_line_buffer.sv
// One image row of pixel storage with a registered read.
// Reads return the contents from before any write in the same cycle.
module mf_line_buffer
    import mf_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output pix_t          rd_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  pix_t          wr_data
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/mf_window_sequencer.sv
// Streams raster pixels through two cascaded line buffers and emits one padded 3x3
// window per image pixel, with row/col scheduling and a single output register.
module mf_window_sequencer
    import mf_pkg::*;
#(
    parameter int unsigned      IMG_W   = 64,
    parameter int unsigned      IMG_H   = 64,
    parameter logic [PIX_W-1:0] PAD_VAL = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  P1,
    output logic [7:0]  P2,
    output logic [7:0]  P3,
    output logic [7:0]  P4,
    output logic [7:0]  P5,
    output logic [7:0]  P6,
    output logic [7:0]  P7,
    output logic [7:0]  P8,
    output logic [7:0]  P9,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [15:0] win_row,
    output logic [15:0] win_col,
    output logic        win_border,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e        state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q;
    logic          flush_last_q;

    // Column history per window row: [0]=top, [1]=middle, [2]=bottom.
    pix_t sh_a_q [3];
    pix_t sh_b_q [3];
    pix_t new_col [3];
    pix_t lb1_rdata, lb2_rdata;

    pix_t          win_q [TAP_N];
    pix_t          taps  [TAP_N];
    logic          win_valid_q, last_q, border_q;
    logic [RW-1:0] wrow_q, c_row;
    logic [CW-1:0] wcol_q, c_col;

    logic adv, accept, emit, shift_en, wr_en, last_win;
    logic top_pad, bot_pad, left_pad, right_pad;

    assign adv       = !win_valid_q || win_ready;
    assign pix_ready = adv && (state_q == StFill || state_q == StRun);
    assign accept    = pix_valid && pix_ready;

    // Reads are addressed with the next column so the data is ready on the accept cycle.
    mf_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .rd_addr (col_d),
        .rd_data (lb1_rdata),
        .we      (wr_en),
        .wr_addr (col_q),
        .wr_data (pix_in)
    );

    mf_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .clk     (clk),
        .rd_addr (col_d),
        .rd_data (lb2_rdata),
        .we      (wr_en),
        .wr_addr (col_q),
        .wr_data (lb1_rdata)
    );

    always_comb begin
        col_d    = col_q;
        emit     = 1'b0;
        shift_en = 1'b0;
        wr_en    = 1'b0;
        last_win = 1'b0;
        c_row    = '0;
        c_col    = '0;
        new_col  = '{lb2_rdata, lb1_rdata, pix_in};
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    shift_en = 1'b1;
                    col_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                end
            end
            StRun: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    shift_en = 1'b1;
                    emit     = (col_q != '0);
                    c_row    = row_q - 1'b1;
                    c_col    = col_q - 1'b1;
                    col_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                end
            end
            StEol: begin
                if (adv) begin
                    emit     = 1'b1;
                    shift_en = 1'b1;
                    c_row    = row_q - 1'b1;
                    c_col    = COL_LAST;
                    col_d    = (row_q == ROW_LAST) ? CW'(1) : '0;
                end
            end
            StFlush: begin
                if (adv) begin
                    emit  = 1'b1;
                    c_row = ROW_LAST;
                    if (flush_last_q) begin
                        c_col    = COL_LAST;
                        last_win = 1'b1;
                        col_d    = '0;
                    end else begin
                        shift_en = 1'b1;
                        c_col    = col_q - 1'b1;
                        col_d    = (col_q == COL_LAST) ? col_q : col_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign top_pad   = (c_row == '0);
    assign bot_pad   = (c_row == ROW_LAST);
    assign left_pad  = (c_col == '0);
    assign right_pad = (c_col == COL_LAST);

    always_comb begin
        taps[TAP_P1] = (top_pad || left_pad)  ? PAD_VAL : sh_a_q[0];
        taps[TAP_P2] = top_pad                ? PAD_VAL : sh_b_q[0];
        taps[TAP_P3] = (top_pad || right_pad) ? PAD_VAL : new_col[0];
        taps[TAP_P4] = left_pad               ? PAD_VAL : sh_a_q[1];
        taps[TAP_P5] = sh_b_q[1];
        taps[TAP_P6] = right_pad              ? PAD_VAL : new_col[1];
        taps[TAP_P7] = (bot_pad || left_pad)  ? PAD_VAL : sh_a_q[2];
        taps[TAP_P8] = bot_pad                ? PAD_VAL : sh_b_q[2];
        taps[TAP_P9] = (bot_pad || right_pad) ? PAD_VAL : new_col[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            flush_last_q <= 1'b0;
            sh_a_q       <= '{default: '0};
            sh_b_q       <= '{default: '0};
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            border_q     <= 1'b0;
            wrow_q       <= '0;
            wcol_q       <= '0;
        end else begin
            col_q <= col_d;
            if (shift_en) begin
                sh_a_q <= sh_b_q;
                sh_b_q <= new_col;
            end
            if (adv) begin
                win_valid_q <= emit;
                last_q      <= last_win;
                if (emit) begin
                    win_q    <= taps;
                    wrow_q   <= c_row;
                    wcol_q   <= c_col;
                    border_q <= top_pad || bot_pad || left_pad || right_pad;
                end
            end
            unique case (state_q)
                StIdle: state_q <= StFill;
                StFill: begin
                    if (accept) begin
                        if (row_q != '0) begin
                            state_q <= StRun;
                        end else if (col_q == COL_LAST) begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (accept && col_q == COL_LAST) begin
                        state_q <= StEol;
                    end
                end
                StEol: begin
                    if (adv) begin
                        if (row_q == ROW_LAST) begin
                            state_q <= StFlush;
                        end else begin
                            row_q   <= row_q + 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StFlush: begin
                    if (adv) begin
                        if (flush_last_q) begin
                            flush_last_q <= 1'b0;
                            row_q        <= '0;
                            state_q      <= StFill;
                        end else if (col_q == COL_LAST) begin
                            flush_last_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign P1         = win_q[TAP_P1];
    assign P2         = win_q[TAP_P2];
    assign P3         = win_q[TAP_P3];
    assign P4         = win_q[TAP_P4];
    assign P5         = win_q[TAP_P5];
    assign P6         = win_q[TAP_P6];
    assign P7         = win_q[TAP_P7];
    assign P8         = win_q[TAP_P8];
    assign P9         = win_q[TAP_P9];
    assign win_valid  = win_valid_q;
    assign win_row    = 16'(wrow_q);
    assign win_col    = 16'(wcol_q);
    assign win_border = border_q;
    assign frame_done = last_q && win_valid_q && win_ready;

endmodule
